led_marquee: RTL and testbench

- 16-LED marquee ("running light") driver for the Nexys-class board top level.
- Divides the 100 MHz board clock into a step tick and advances a 16-bit LED pattern once per tick.
- Slide switches select pause, direction and pattern mode.
- Sits directly between the board switch inputs and the LED outputs; no other interfaces.

---
 rtl/led_marquee.sv | 96 +++++++++
 tb/tb_led_marquee.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/led_marquee.sv
// Purpose : 16-LED running-light driver; divides the board clock into a step tick and advances the LED pattern.
// Latency : LED is a pure register; a step tick on edge n shows the new pattern right after edge n.
// Backpr. : none; SW[0] pauses the divider and the pattern, and a mode change restarts from 16'h0001.
//
// Ports:
//   CLK100MHZ  - board clock; all logic on its rising edge
//   CPU_RESETN - synchronous reset, active HIGH (1 at a rising edge resets the block)
//   SW[0]      - pause (hold divider count and LED)
//   SW[1]      - rotate direction (0 = left, 1 = right); only used by the rotate modes
//   SW[3:2]    - mode: 00/11 rotate, 01 bounce, 10 fill/drain; SW[15:4] unused
//   LED        - registered pattern, bit 0 = rightmost LED
module led_marquee #(
   parameter int div_num = 50_000_000
) (
   input  logic        CLK100MHZ,
   input  logic        CPU_RESETN,
   input  logic [15:0] SW,
   output logic [15:0] LED
);

   localparam int            CW   = $clog2(div_num);
   localparam logic [CW-1:0] LAST = CW'(div_num - 1);

   typedef enum logic {FILL, DRAIN} phase_t;
   typedef enum logic {UP, DOWN}    dir_t;

   logic [CW-1:0] count;
   logic [1:0]    mode_q;
   phase_t        phase;
   dir_t          dir;

   logic mode_chg;
   logic step;
   logic unused_sw;

   assign mode_chg  = (SW[3:2] != mode_q);
   assign step      = !SW[0] && (count == LAST);
   assign unused_sw = ^SW[15:4];

   always_ff @(posedge CLK100MHZ) begin
      if (CPU_RESETN) begin
         LED    <= 16'h0001;
         count  <= '0;
         phase  <= FILL;
         dir    <= UP;
         mode_q <= SW[3:2];
      end else if (mode_chg) begin
         // A new mode always restarts from a single lit LED, even while paused.
         LED    <= 16'h0001;
         count  <= '0;
         phase  <= FILL;
         dir    <= UP;
         mode_q <= SW[3:2];
      end else if (step) begin
         count <= '0;
         case (mode_q)
            2'b01: begin
               // Bounce: turn around at either end instead of shifting off the edge.
               if (dir == UP) begin
                  if (LED == 16'h8000) begin
                     dir <= DOWN;
                     LED <= 16'h4000;
                  end else begin
                     LED <= {LED[14:0], 1'b0};
                  end
               end else begin
                  if (LED == 16'h0001) begin
                     dir <= UP;
                     LED <= 16'h0002;
                  end else begin
                     LED <= {1'b0, LED[15:1]};
                  end
               end
            end
            2'b10: begin
               // Fill shifts ones in until all lit, drain shifts zeros in until all dark.
               if (phase == FILL) begin
                  LED <= {LED[14:0], 1'b1};
                  if (LED[14:0] == 15'h7FFF) phase <= DRAIN;
               end else begin
                  LED <= {LED[14:0], 1'b0};
                  if (LED[14:0] == 15'h0000) phase <= FILL;
               end
            end
            default: begin
               // Rotate; direction is sampled at each step without reloading the pattern.
               if (SW[1]) LED <= {LED[0], LED[15:1]};
               else       LED <= {LED[14:0], LED[15]};
            end
         endcase
      end else if (!SW[0]) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: tb/tb_led_marquee.sv
// Purpose : self-checking bench for led_marquee (div_num = 5).
// Latency : compares LED on the falling edge after each rising edge.
// Backpr. : none; inputs change only on falling edges.
module tb_led_marquee;

   localparam int DIV = 5;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] sw  = 16'h0000;
   logic [15:0] led;

   int checks = 0;
   int errors = 0;

   led_marquee #(.div_num(DIV)) dut (
      .CLK100MHZ (clk),
      .CPU_RESETN(rst),
      .SW        (sw),
      .LED       (led)
   );

   always #5 clk = ~clk;

   // Reference model: position k within the current mode's step sequence,
   // plus the number of unpaused cycles since the last step.
   int       m_k     = 0;
   int       m_cnt   = 0;
   logic [1:0] m_mode = 2'b00;
   bit       m_valid = 1'b0;

   function automatic logic [15:0] fill_val(input int k);
      int v;
      if (k <= 15)      v = (1 << (k + 1)) - 1;
      else if (k <= 30) v = (32'hFFFF << (k - 15)) & 32'hFFFF;
      else              v = 0;
      return v[15:0];
   endfunction

   function automatic logic [15:0] model_led();
      logic [15:0] one;
      one = 16'h0001;
      case (m_mode)
         2'b01:   return (m_k <= 15) ? (one << m_k) : (one << (30 - m_k));
         2'b10:   return fill_val(m_k);
         default: return one << m_k;
      endcase
   endfunction

   task automatic model_edge();
      if (rst) begin
         m_valid = 1'b1;
         m_k = 0; m_cnt = 0; m_mode = sw[3:2];
      end else if (!m_valid) begin
         // nothing known before the first reset
      end else if (sw[3:2] != m_mode) begin
         m_k = 0; m_cnt = 0; m_mode = sw[3:2];
      end else if (!sw[0]) begin
         if (m_cnt == DIV - 1) begin
            m_cnt = 0;
            case (m_mode)
               2'b01:   m_k = (m_k + 1) % 30;
               2'b10:   m_k = (m_k + 1) % 32;
               default: m_k = sw[1] ? (m_k + 15) % 16 : (m_k + 1) % 16;
            endcase
         end else begin
            m_cnt++;
         end
      end
   endtask

   task automatic check(input string name, input logic [15:0] exp);
      checks++;
      if (led !== exp) begin
         errors++;
         $display("FAIL %s: LED=%h expected %h at %0t", name, led, exp, $time);
      end
   endtask

   // One clock: model follows the same edge, compare on the falling edge.
   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (m_valid) check("model", model_led());
   endtask

   typedef struct {
      logic        rst;
      logic [15:0] sw;
      int          n;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs[37];

   initial begin
      // {reset, switches, cycles to run, LED expected afterwards}
      vecs[0]  = '{1'b1, 16'h0000, 10,  16'h0001}; // reset held
      vecs[1]  = '{1'b0, 16'h0000, 4,   16'h0001}; // no step yet
      vecs[2]  = '{1'b0, 16'h0000, 1,   16'h0002}; // first step div_num after release
      vecs[3]  = '{1'b0, 16'h0001, 200, 16'h0002}; // paused
      vecs[4]  = '{1'b0, 16'h0000, 5,   16'h0004};
      vecs[5]  = '{1'b0, 16'h0002, 10,  16'h0001}; // rotate right
      vecs[6]  = '{1'b0, 16'h0002, 5,   16'h8000}; // right wrap
      vecs[7]  = '{1'b0, 16'h0002, 5,   16'h4000};
      vecs[8]  = '{1'b0, 16'h0000, 5,   16'h8000}; // reversed without reload
      vecs[9]  = '{1'b0, 16'h0004, 1,   16'h0001}; // mode change -> bounce
      vecs[10] = '{1'b0, 16'h0006, 5,   16'h0002}; // SW[1] ignored
      vecs[11] = '{1'b0, 16'h0006, 70,  16'h8000};
      vecs[12] = '{1'b0, 16'h0006, 5,   16'h4000}; // top turnaround
      vecs[13] = '{1'b0, 16'h0004, 70,  16'h0001}; // 30-step period
      vecs[14] = '{1'b0, 16'h0004, 5,   16'h0002}; // bottom turnaround
      vecs[15] = '{1'b0, 16'h0008, 1,   16'h0001}; // mode change -> fill
      vecs[16] = '{1'b0, 16'h0008, 75,  16'hFFFF};
      vecs[17] = '{1'b0, 16'h0008, 5,   16'hFFFE}; // drain starts
      vecs[18] = '{1'b0, 16'h000A, 75,  16'h0000};
      vecs[19] = '{1'b0, 16'h000A, 5,   16'h0001}; // 32-step period
      vecs[20] = '{1'b0, 16'h000A, 5,   16'h0003};
      vecs[21] = '{1'b0, 16'h0005, 1,   16'h0001}; // mode change beats pause
      vecs[22] = '{1'b0, 16'h0005, 20,  16'h0001};
      vecs[23] = '{1'b0, 16'h0004, 5,   16'h0002};
      vecs[24] = '{1'b0, 16'h0004, 3,   16'h0002};
      vecs[25] = '{1'b1, 16'h0004, 5,   16'h0001}; // reset mid-run
      vecs[26] = '{1'b0, 16'h0004, 4,   16'h0001}; // full delay after release
      vecs[27] = '{1'b0, 16'h0004, 1,   16'h0002};
      vecs[28] = '{1'b0, 16'h0000, 1,   16'h0001}; // mode change -> rotate
      vecs[29] = '{1'b0, 16'h0000, 90,  16'h0004}; // 18 steps
      vecs[30] = '{1'b0, 16'h0000, 2,   16'h0004};
      vecs[31] = '{1'b0, 16'h0001, 100, 16'h0004}; // pause with count held at 2
      vecs[32] = '{1'b0, 16'h0000, 2,   16'h0004};
      vecs[33] = '{1'b0, 16'h0000, 1,   16'h0008}; // resumes from held count
      vecs[34] = '{1'b0, 16'h0001, 7,   16'h0008};
      vecs[35] = '{1'b1, 16'h0001, 1,   16'h0001}; // reset while paused
      vecs[36] = '{1'b0, 16'h0001, 50,  16'h0001};

      @(negedge clk);
      for (int v = 0; v < 37; v++) begin
         rst = vecs[v].rst;
         sw  = vecs[v].sw;
         for (int c = 0; c < vecs[v].n; c++) cycle();
         check($sformatf("vec%0d", v), vecs[v].exp);
      end

      // Randomized segments against the model.
      for (int seg = 0; seg < 150; seg++) begin
         int len;
         rst = ($urandom_range(0, 99) < 5);
         if ($urandom_range(0, 3) == 0) sw[3:2] = 2'($urandom_range(0, 3));
         sw[0] = ($urandom_range(0, 3) == 0);
         sw[1] = 1'($urandom_range(0, 1));
         sw[15:4] = 12'($urandom());
         len = $urandom_range(1, 40);
         for (int c = 0; c < len; c++) cycle();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
